// File: rtl/axi_stream_strip_header_pkg.sv
// Shared types and byte-lane helpers for the AXI Stream header insert/strip stages.
// Helpers work on a maximum-width bus; callers size-cast results to their width.
package axi_stream_strip_header_pkg;

  localparam int MAX_BYTES = 64;
  localparam int MAX_WD    = 8 * MAX_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_BODY,
    ST_TAIL
  } strip_state_e;

  function automatic int keep_popcount(input logic [MAX_BYTES-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_BYTES; i++) cnt += int'(keep[i]);
    return cnt;
  endfunction

  // cnt ones at the top of a lanes-wide keep bus; bits at and above lanes stay 0.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int lanes, input int cnt);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) m[i] = (i < lanes) && (i >= lanes - cnt);
    return m;
  endfunction

  function automatic logic [MAX_WD-1:0] shl_bytes(input logic [MAX_WD-1:0] d, input int nb);
    return d << (8 * nb);
  endfunction

  function automatic logic [MAX_WD-1:0] shr_bytes(input logic [MAX_WD-1:0] d, input int nb);
    return d >> (8 * nb);
  endfunction

endpackage

// File: rtl/axis_out_slot.sv
// One-entry valid/ready output register; holds its beat stable while valid & !ready.
module axis_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  assign free = !valid || ready;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      // NOTE: the data register is reset too, so outputs read 0 rather than X after reset.
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips n leading bytes of each packet onto a header channel and realigns the payload.
// Optional macro AXIS_STRIP_ERR_EN adds the err_short pulse output.
module axi_stream_strip_header
  import axi_stream_strip_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_strip,
  input  logic [CNT_WD-1:0]       strip_bytes,
  output logic                    ready_strip,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
`ifdef AXIS_STRIP_ERR_EN
  ,
  output logic                    err_short
`endif
);

  strip_state_e state, state_next;

  logic [CNT_WD-1:0]       n_q, n_sat, pend_q;
  logic [DATA_WD-1:0]      res_q, data_shl, data_shr;
  logic [MAX_WD-1:0]       data_ext;
  logic [MAX_BYTES-1:0]    keep_ext;
  logic                    in_hs, hdr_free, out_free;
  logic                    hdr_load, out_load, out_last;
  logic [DATA_WD-1:0]      hdr_data, out_data;
  logic [DATA_BYTE_WD-1:0] hdr_keep, out_keep;
  logic [DATA_WD+DATA_BYTE_WD-1:0]   hdr_q;
  logic [DATA_WD+DATA_BYTE_WD:0]     out_q;
  int k, n, n_eff, r_eff, h, total;

  assign n_sat = (int'(strip_bytes) > DATA_BYTE_WD) ? CNT_WD'(DATA_BYTE_WD) : strip_bytes;
  assign ready_strip = (state == ST_IDLE);
  assign ready_in = (state == ST_FIRST) ? (hdr_free && out_free) :
                    (state == ST_BODY)  ? out_free : 1'b0;
  assign in_hs = valid_in && ready_in;

  // n=0 and n=DATA_BYTE_WD both realign by a full beat in BODY, i.e. pass-through.
  always_comb begin
    data_ext = '0;
    data_ext[DATA_WD-1:0] = data_in;
    keep_ext = '0;
    keep_ext[DATA_BYTE_WD-1:0] = keep_in;
    k        = keep_popcount(keep_ext);
    n        = int'(n_q);
    n_eff    = (n == 0) ? DATA_BYTE_WD : n;
    r_eff    = DATA_BYTE_WD - n_eff;
    h        = (k < n) ? k : n;
    total    = r_eff + k;
    data_shl = DATA_WD'(shl_bytes(data_ext, n_eff));
    data_shr = DATA_WD'(shr_bytes(data_ext, r_eff));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (valid_strip) state_next = ST_FIRST;
      ST_FIRST: if (in_hs) state_next = last_in ? ST_IDLE : ST_BODY;
      ST_BODY:  if (in_hs && last_in) state_next = (total > DATA_BYTE_WD) ? ST_TAIL : ST_IDLE;
      ST_TAIL:  if (out_free) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_load = 1'b0;
    hdr_data = data_in;
    hdr_keep = DATA_BYTE_WD'(keep_mask(DATA_BYTE_WD, h));
    out_load = 1'b0;
    out_data = '0;
    out_keep = '0;
    out_last = 1'b0;
    unique case (state)
      ST_FIRST: if (in_hs) begin
        hdr_load = (h > 0);
        if (n == 0) begin
          out_load = 1'b1;
          out_data = data_in;
          out_keep = keep_in;
          out_last = last_in;
        end else if (last_in && k > n) begin
          out_load = 1'b1;
          out_data = data_shl;
          out_keep = DATA_BYTE_WD'(keep_mask(DATA_BYTE_WD, k - n));
          out_last = 1'b1;
        end
      end
      ST_BODY: if (in_hs) begin
        out_load = 1'b1;
        out_data = res_q | data_shr;
        if (last_in && total <= DATA_BYTE_WD) begin
          out_keep = DATA_BYTE_WD'(keep_mask(DATA_BYTE_WD, total));
          out_last = 1'b1;
        end else begin
          out_keep = '1;
        end
      end
      ST_TAIL: if (out_free) begin
        out_load = 1'b1;
        out_data = res_q;
        out_keep = DATA_BYTE_WD'(keep_mask(DATA_BYTE_WD, int'(pend_q)));
        out_last = 1'b1;
      end
      default: ;
    endcase
    // Disabled lanes always leave as zero.
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (!hdr_keep[i]) hdr_data[8*i +: 8] = '0;
      if (!out_keep[i]) out_data[8*i +: 8] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      res_q  <= '0;
      pend_q <= '0;
    end else begin
      if (state == ST_IDLE && valid_strip) n_q <= n_sat;
      if (in_hs) res_q <= data_shl;
      if (state == ST_BODY && in_hs && last_in && total > DATA_BYTE_WD)
        pend_q <= CNT_WD'(total - DATA_BYTE_WD);
    end
  end

`ifdef AXIS_STRIP_ERR_EN
  // Only a single-beat packet can end with no payload or fewer than n bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_short <= 1'b0;
    else        err_short <= (state == ST_FIRST) && in_hs && last_in && (k <= n);
  end
`endif

  axis_out_slot #(.W(DATA_WD + DATA_BYTE_WD)) u_hdr_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hdr_load),
    .load_data ({hdr_data, hdr_keep}),
    .ready     (ready_hdr),
    .valid     (valid_hdr),
    .data      (hdr_q),
    .free      (hdr_free)
  );

  axis_out_slot #(.W(DATA_WD + DATA_BYTE_WD + 1)) u_out_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (out_load),
    .load_data ({out_data, out_keep, out_last}),
    .ready     (ready_out),
    .valid     (valid_out),
    .data      (out_q),
    .free      (out_free)
  );

  assign {header_out, keep_hdr}         = hdr_q;
  assign {data_out, keep_out, last_out} = out_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench for axi_stream_strip_header: byte-queue reference model plus
// per-handshake and hold-stability checks on both output channels.
module tb_axi_stream_strip_header;

  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB + 1);

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_strip = 1'b0;
  logic [CW-1:0] strip_bytes = '0;
  logic          ready_strip;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_hdr;
  logic [DW-1:0] header_out;
  logic [NB-1:0] keep_hdr;
  logic          ready_hdr = 1'b1;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          last_out;
  logic          ready_out = 1'b1;
`ifdef AXIS_STRIP_ERR_EN
  logic          err_short;
`endif

  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_err = 0;
  int    m_err = 0;
  int    err_seen = 0;
  bit    rnd_ready = 1'b0;
  beat_t exp_pay[$], exp_hdr[$], m_pay[$], m_hdr[$];
  beat_t cur_pay, cur_hdr, prev_pay, prev_hdr;
  bit    prev_pv, prev_pr, prev_hv, prev_hr;

  axi_stream_strip_header #(.DATA_WD(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_strip (valid_strip),
    .strip_bytes (strip_bytes),
    .ready_strip (ready_strip),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .keep_in     (keep_in),
    .last_in     (last_in),
    .ready_in    (ready_in),
    .valid_hdr   (valid_hdr),
    .header_out  (header_out),
    .keep_hdr    (keep_hdr),
    .ready_hdr   (ready_hdr),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .keep_out    (keep_out),
    .last_out    (last_out),
    .ready_out   (ready_out)
`ifdef AXIS_STRIP_ERR_EN
    ,
    .err_short   (err_short)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic [NB-1:0] kp, input logic l);
    beat_t b;
    b.data = d;
    b.keep = kp;
    b.last = l;
    return b;
  endfunction

  // Reference: header = first min(n, first-beat bytes); payload = remaining bytes repacked.
  function automatic void model_packet(input byte_q_t pkt, input int n_raw);
    int      n, l, k0, h, idx;
    beat_t   b;
    byte_q_t pay;
    n  = (n_raw > NB) ? NB : n_raw;
    l  = pkt.size();
    k0 = (l < NB) ? l : NB;
    h  = (n < k0) ? n : k0;
    m_hdr.delete();
    m_pay.delete();
    if (h > 0) begin
      b = '0;
      for (int i = 0; i < h; i++) begin
        b.data[DW-1-8*i -: 8] = pkt[i];
        b.keep[NB-1-i] = 1'b1;
      end
      m_hdr.push_back(b);
    end
    for (int i = h; i < l; i++) pay.push_back(pkt[i]);
    idx = 0;
    while (idx < pay.size()) begin
      b = '0;
      for (int j = 0; j < NB && idx < pay.size(); j++) begin
        b.data[DW-1-8*j -: 8] = pay[idx];
        b.keep[NB-1-j] = 1'b1;
        idx++;
      end
      b.last = (idx == pay.size());
      m_pay.push_back(b);
    end
    m_err = (l < n || pay.size() == 0) ? 1 : 0;
  endfunction

  task automatic push_model();
    foreach (m_hdr[i]) exp_hdr.push_back(m_hdr[i]);
    foreach (m_pay[i]) exp_pay.push_back(m_pay[i]);
    exp_err += m_err;
  endtask

  task automatic send_cmd(input int n_raw);
    int cyc = 0;
    bit hs = 1'b0;
    valid_strip = 1'b1;
    strip_bytes = CW'(n_raw);
    while (!hs && cyc < 300) begin
      @(negedge clk);
      hs = ready_strip;
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_strip = 1'b0;
    if (!hs) check("strip_cmd_timeout", 64'(hs), 64'(1));
  endtask

  task automatic drive_beat(input byte_q_t pkt, input int bi, input bit last);
    int cyc = 0;
    bit hs = 1'b0;
    valid_in = 1'b1;
    data_in  = '0;
    keep_in  = '0;
    last_in  = last;
    for (int j = 0; j < NB; j++) begin
      if (bi * NB + j < pkt.size()) begin
        data_in[DW-1-8*j -: 8] = pkt[bi*NB+j];
        keep_in[NB-1-j] = 1'b1;
      end
    end
    while (!hs && cyc < 300) begin
      @(negedge clk);
      hs = ready_in;
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
    if (!hs) check("in_beat_timeout", 64'(hs), 64'(1));
  endtask

  task automatic send_packet(input byte_q_t pkt, input int n_raw);
    int nbeats;
    model_packet(pkt, n_raw);
    push_model();
    send_cmd(n_raw);
    nbeats = (pkt.size() + NB - 1) / NB;
    for (int b = 0; b < nbeats; b++) drive_beat(pkt, b, b == nbeats - 1);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check({name, "_pay_left"}, 64'(exp_pay.size()), 64'(0));
    check({name, "_hdr_left"}, 64'(exp_hdr.size()), 64'(0));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) begin
      ready_out = ($urandom_range(0, 3) != 0);
      ready_hdr = ($urandom_range(0, 2) != 0);
    end else begin
      ready_out = 1'b1;
      ready_hdr = 1'b1;
    end
  end

  always @(negedge clk) begin
    cur_pay = {data_out, keep_out, last_out};
    cur_hdr = {header_out, keep_hdr, 1'b0};
    if (!rst_n) begin
      prev_pv = 1'b0;
      prev_hv = 1'b0;
    end else begin
      if (prev_pv && !prev_pr) check("pay_stable", 64'({valid_out, cur_pay}), 64'({1'b1, prev_pay}));
      if (prev_hv && !prev_hr) check("hdr_stable", 64'({valid_hdr, cur_hdr}), 64'({1'b1, prev_hdr}));
      if (valid_out && ready_out) begin
        if (exp_pay.size() == 0) check("pay_unexpected", 64'(valid_out), 64'(0));
        else check("pay_beat", 64'(cur_pay), 64'(exp_pay.pop_front()));
      end
      if (valid_hdr && ready_hdr) begin
        if (exp_hdr.size() == 0) check("hdr_unexpected", 64'(valid_hdr), 64'(0));
        else check("hdr_beat", 64'(cur_hdr), 64'(exp_hdr.pop_front()));
      end
`ifdef AXIS_STRIP_ERR_EN
      if (err_short) err_seen++;
`endif
      prev_pv  = valid_out;
      prev_pr  = ready_out;
      prev_pay = cur_pay;
      prev_hv  = valid_hdr;
      prev_hr  = ready_hdr;
      prev_hdr = cur_hdr;
    end
  end

  initial begin
    byte_q_t pkt, pkt10, pkt2, rp;
    int      l, n;
    pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
            8'hC0, 8'hC1, 8'hC2, 8'hC3};
    pkt10 = pkt[0:9];
    pkt2  = pkt[0:1];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_strip", 64'(ready_strip), 64'(1));
    check("rst_ready_in", 64'(ready_in), 64'(0));
    check("rst_valids", 64'({valid_out, valid_hdr}), 64'(0));
    check("rst_out_bus", 64'({data_out, keep_out, last_out}), 64'(0));
    check("rst_hdr_bus", 64'({header_out, keep_hdr}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Strip 1 on three full beats.
    model_packet(pkt, 1);
    check("pin1_hdr", 64'(m_hdr[0]), 64'(mk_beat(32'hA000_0000, 4'b1000, 1'b0)));
    check("pin1_npay", 64'(m_pay.size()), 64'(3));
    check("pin1_pay0", 64'(m_pay[0]), 64'(mk_beat(32'hA1A2_A3B0, 4'b1111, 1'b0)));
    check("pin1_pay2", 64'(m_pay[2]), 64'(mk_beat(32'hC1C2_C300, 4'b1110, 1'b1)));
    send_packet(pkt, 1);

    // Strip 2, last beat two bytes: no tail beat.
    model_packet(pkt10, 2);
    check("pin2_npay", 64'(m_pay.size()), 64'(2));
    check("pin2_pay1", 64'(m_pay[1]), 64'(mk_beat(32'hB2B3_C0C1, 4'b1111, 1'b1)));
    send_packet(pkt10, 2);

    // Strip 0 pass-through, strip 4 whole first beat.
    model_packet(pkt, 0);
    check("pin0_nhdr", 64'(m_hdr.size()), 64'(0));
    check("pin0_pay0", 64'(m_pay[0]), 64'(mk_beat(32'hA0A1_A2A3, 4'b1111, 1'b0)));
    send_packet(pkt, 0);
    model_packet(pkt, 4);
    check("pin4_hdr", 64'(m_hdr[0]), 64'(mk_beat(32'hA0A1_A2A3, 4'b1111, 1'b0)));
    check("pin4_npay", 64'(m_pay.size()), 64'(2));
    send_packet(pkt, 4);

    // Strip 3 on a two-byte packet: header only, short.
    model_packet(pkt2, 3);
    check("pin3_hdr", 64'(m_hdr[0]), 64'(mk_beat(32'hA0A1_0000, 4'b1100, 1'b0)));
    check("pin3_npay", 64'(m_pay.size()), 64'(0));
    check("pin3_err", 64'(m_err), 64'(1));
    send_packet(pkt2, 3);

    // Oversized strip count saturates to a full beat.
    send_packet(pkt10, 7);
    drain("directed");

    rnd_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      rp.delete();
      l = $urandom_range(1, 13);
      n = $urandom_range(0, 5);
      for (int i = 0; i < l; i++) rp.push_back(8'($urandom));
      send_packet(rp, n);
    end
    rnd_ready = 1'b0;
    drain("random");

    // Reset in the middle of BODY, then a clean packet.
    model_packet(pkt, 1);
    push_model();
    send_cmd(1);
    drive_beat(pkt, 0, 1'b0);
    drive_beat(pkt, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valids", 64'({valid_out, valid_hdr}), 64'(0));
    check("midrst_ready", 64'({ready_strip, ready_in}), 64'(2'b10));
    exp_pay.delete();
    exp_hdr.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_packet(pkt10, 2);
    drain("post_reset");

`ifdef AXIS_STRIP_ERR_EN
    check("err_short_count", 64'(err_seen), 64'(exp_err));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
